// File: rtl/shift_pkg.sv
// Shared encodings and default sizes for the iterative right shifter.
package shift_pkg;

    localparam int unsigned WIDTH_DEFAULT   = 32;
    localparam int unsigned SHAMT_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/shift_right_stage.sv
// One barrel stage: shifts right by 2^k with the given fill bit when enabled, else passes through.
module shift_right_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]           in,
    input  logic                       fill,
    input  logic                       enable,
    input  logic [$clog2(SHAMT_W)-1:0] k,
    output logic [WIDTH-1:0]           out
);

    logic [SHAMT_W-1:0] w_amt;
    logic [WIDTH-1:0]   w_fill_mask;

    assign w_amt       = SHAMT_W'(1) << k;
    // Ones in the top 2^k positions, i.e. the bits vacated by the shift.
    assign w_fill_mask = ~({WIDTH{1'b1}} >> w_amt);

    always_comb begin
        out = in;
        if (enable) begin
            out = (in >> w_amt) | (fill ? w_fill_mask : '0);
        end
    end

endmodule

// File: rtl/shift_right_iter.sv
// Multi-cycle right shifter: one shamt bit per clock, LSB first, start/ready handshake.
// Define SHIFT_RIGHT_ARITH_EN to enable arithmetic (sign-fill) shifts via the arith input.
module shift_right_iter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEFAULT,
    parameter int unsigned SHAMT_W = SHAMT_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_shift,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(SHAMT_W);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_result;
    logic [SHAMT_W-1:0] r_shamt;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_start;
    logic               w_last;
    logic               w_fill;
    logic [WIDTH-1:0]   w_stage_out;

    assign w_start = ctrl_shift && (r_state != RUN);
    assign w_last  = (r_cnt == CNT_W'(SHAMT_W - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (ctrl_shift) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = ctrl_shift ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_work   <= '0;
            r_result <= '0;
            r_shamt  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_work  <= data_in;
                r_shamt <= shamt;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_work <= w_stage_out;
                r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_result <= w_stage_out;
                end
            end
        end
    end

`ifdef SHIFT_RIGHT_ARITH_EN
    logic r_fill;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_fill <= 1'b0;
        end else if (w_start) begin
            r_fill <= arith & data_in[WIDTH-1];
        end
    end

    assign w_fill = r_fill;
`else
    logic w_unused_arith;

    assign w_unused_arith = arith;
    assign w_fill         = 1'b0;
`endif

    shift_right_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .in     (r_work),
        .fill   (w_fill),
        .enable (r_shamt[r_cnt]),
        .k      (r_cnt),
        .out    (w_stage_out)
    );

    assign data_result    = r_result;
    assign data_resultRDY = (r_state == DONE);
    assign busy           = (r_state == RUN);

endmodule

// File: tb/tb_shift_right_iter.sv
// Scoreboard bench for shift_right_iter: stimulus pushes expected results, a monitor checks on RDY.
module tb_shift_right_iter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_shift;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q_exp[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    shift_right_iter dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_shift     (ctrl_shift),
        .data_in        (data_in),
        .shamt          (shamt),
        .arith          (arith),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every RDY pulse must match the oldest expectation, in value and cycle.
    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            if (q_exp.size() == 0) begin
                check("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                check({e.name, "_data"}, data_result, e.data);
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a start for one cycle; result expected 6 cycles after the issue cycle.
    task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic a,
                         input logic [31:0] exp, input string name, input bit push);
        exp_t e;
        ctrl_shift = 1'b1;
        data_in    = d;
        shamt      = s;
        arith      = a;
        if (push) begin
            e.data = exp;
            e.cyc  = cyc + 6;
            e.name = name;
            q_exp.push_back(e);
        end
        tick();
        ctrl_shift = 1'b0;
        data_in    = ~d;
        shamt      = ~s;
        arith      = ~a;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && q_exp.size() != 0; i++) tick();
        if (q_exp.size() != 0) begin
            check("drain_timeout", 32'(q_exp.size()), 32'd0);
            q_exp.delete();
        end
    endtask

    initial begin
        reset      = 1'b0;
        ctrl_shift = 1'b1;
        data_in    = 32'hFFFF_FFFF;
        shamt      = 5'd3;
        arith      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_rdy", 32'(data_resultRDY), 32'd0);
            check("reset_result", data_result, 32'd0);
        end
        ctrl_shift = 1'b0;
        reset      = 1'b1;
        tick();

        // Basic logical shift, with busy checked across the run.
        issue(32'h8000_00F0, 5'd4, 1'b0, 32'h0800_000F, "lsr4", 1'b1);
        for (int i = 1; i <= 5; i++) begin
            check("busy_run", 32'(busy), 32'd1);
            tick();
        end
        check("busy_done", 32'(busy), 32'd0);
        drain();
        tick();
        check("result_held", data_result, 32'h0800_000F);

`ifdef SHIFT_RIGHT_ARITH_EN
        issue(32'h8000_00F0, 5'd4, 1'b1, 32'hF800_000F, "asr4", 1'b1);
        drain();
        issue(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, "asr31", 1'b1);
        drain();
`else
        issue(32'h8000_00F0, 5'd4, 1'b1, 32'h0800_000F, "asr4_off", 1'b1);
        drain();
        issue(32'h8000_0000, 5'd31, 1'b1, 32'h0000_0001, "asr31_off", 1'b1);
        drain();
`endif
        issue(32'hDEAD_BEEF, 5'd0, 1'b0, 32'hDEAD_BEEF, "shamt0", 1'b1);
        drain();
        issue(32'hF0F0_F0F0, 5'd31, 1'b0, 32'h0000_0001, "lsr31", 1'b1);
        drain();

        // Start in cycle 3 is ignored; start in the DONE cycle is accepted.
        issue(32'h0000_FF00, 5'd8, 1'b0, 32'h0000_00FF, "first", 1'b1);
        tick();
        tick();
        ctrl_shift = 1'b1;
        data_in    = 32'hFFFF_FFFF;
        shamt      = 5'd1;
        tick();
        ctrl_shift = 1'b0;
        tick();
        tick();
        issue(32'h1234_5678, 5'd12, 1'b0, 32'h0001_2345, "b2b", 1'b1);
        drain();

        // Reset in cycle 3 aborts without an RDY pulse.
        issue(32'hAAAA_AAAA, 5'd3, 1'b0, 32'h0, "aborted", 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", data_result, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();

`ifdef SHIFT_RIGHT_ARITH_EN
        issue(32'h8765_4321, 5'd16, 1'b1, 32'hFFFF_8765, "after_abort", 1'b1);
`else
        issue(32'h8765_4321, 5'd16, 1'b1, 32'h0000_8765, "after_abort", 1'b1);
`endif
        drain();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_right_iter.md
Name: shift_right_iter

Overview:
- Multi-cycle 32-bit right shifter for the processor's execute stage; counterpart to the combinational left barrel shifter.
- Serialises the five barrel stages over time: one shamt bit is applied per clock, LSB first.
- Uses the same start/ready handshake style as the multdiv unit, so the execute stage can stall on it.
- Supports logical shift right, and arithmetic shift right when the optional feature is compiled in.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH); also the number of iteration cycles.

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  synchronous, active-low reset
- ctrl_shift  input  1  start strobe; sampled only when not busy
- data_in  input  WIDTH  operand
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill)
- data_result  output  WIDTH  shifted result; held stable until the next accepted start
- data_resultRDY  output  1  one-cycle pulse when data_result becomes valid
- busy  output  1  high while an operation is in progress

Behaviour:
- Reset (reset==0 at a rising edge) forces:
  - state IDLE, data_result=0, data_resultRDY=0, busy=0, stage counter=0;
  - all internal registers cleared. Reset asserted mid-operation aborts the operation; no RDY pulse follows.
- FSM states:
  - IDLE to RUN: on ctrl_shift=1. Capture data_in into the working register, shamt into a shift register, fill bit (arith & data_in[WIDTH-1]), counter=0.
  - RUN: each edge, if the current shamt bit k is 1, shift the working register right by 2^k, filling with the fill bit. Then k++. After stage SHAMT_W-1, go to DONE.
  - DONE: data_resultRDY=1, busy=0, data_result=working register. Next edge goes to IDLE, or to RUN if ctrl_shift=1 (back-to-back accepted).
- Latency: ctrl_shift high in cycle 0 gives busy high in cycles 1..5 and data_resultRDY high in cycle 6 only. Fixed for every shamt, including 0.
- ctrl_shift while busy=1 is ignored; operands are not re-sampled.
- data_in, shamt and arith may change freely after the capture edge.
- data_result updates only on entry to DONE; otherwise it holds its last value.
- Fill bit is latched at capture. Arithmetic shift of a negative value by 31 yields all ones; a logical shift yields 0 or 1.
- No overflow is possible; shamt is range-limited by its width.

Optional Feature:
- Macro SHIFT_RIGHT_ARITH_EN.
- Defined: the arith input selects sign fill as described above.
- Undefined: the arith port still exists but is ignored; fill is always 0, giving logical shift only, and the sign-capture logic is removed.

Decomposition:
- Package shift_pkg holds:
  - state encoding constants IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - WIDTH_DEFAULT=32 and SHAMT_W_DEFAULT=5.
- Sub-module shift_right_stage (combinational) takes in, fill, enable and stage index k. Output is in >> 2^k with fill bits when enable is high, otherwise in. It is instantiated once, and its index is driven by the counter.

Test Plan:
- Reset held low 3 cycles, including while ctrl_shift=1 -> all outputs 0; no RDY.
- data_in=32'h8000_00F0, shamt=4, arith=0 -> RDY in cycle 6, data_result=32'h0800_000F.
- data_in=32'h8000_00F0, shamt=4, arith=1, with SHIFT_RIGHT_ARITH_EN defined -> data_result=32'hF800_000F. With it undefined -> 32'h0800_000F.
- shamt=0 with data_in=32'hDEAD_BEEF -> result 32'hDEAD_BEEF after the full 6-cycle latency. shamt=31, arith=1, data_in=32'h8000_0000 -> 32'hFFFF_FFFF.
- Second ctrl_shift in cycle 3 with different operands -> ignored, first result correct. New ctrl_shift in the DONE cycle -> accepted, next RDY 6 cycles later.
- reset low in cycle 3 of an operation -> busy=0 and data_result=0 next cycle; no RDY pulse. A fresh operation afterwards completes normally.
